// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between a FIFO producer/consumer pair and fifo_ctrl.
// The master side issues push/pop/flush; the slave side is the controller.
interface fifo_ctrl_if #(
  parameter int CW = 4
);
  logic          push;
  logic          pop;
  logic          flush;
  logic          wden;
  logic          rden;
  logic          WrPtrClr;
  logic          RdPtrClr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          rd_valid;
  logic          ovf;
  logic          udf;
  logic          busy;

  modport master (
    output push, pop, flush,
    input  wden, rden, WrPtrClr, RdPtrClr, count, full, empty,
           rd_valid, ovf, udf, busy
  );

  modport slave (
    input  push, pop, flush,
    output wden, rden, WrPtrClr, RdPtrClr, count, full, empty,
           rd_valid, ovf, udf, busy
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Occupancy/handshake controller for an external 8-entry, 9-bit buffer.
// One-cycle INIT clears the buffer pointers; RUN tracks count and sticky ovf/udf.
module fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic       clk,
  input  logic       reset,
  fifo_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_COUNT = {CW{1'b0}};

  state_t        stateR;
  state_t        stateNextS;
  logic [CW-1:0] countR;
  logic [CW-1:0] countNextS;
  logic          ovfR;
  logic          udfR;
  logic          rdValidR;
  logic          runS;
  logic          fullS;
  logic          emptyS;
  logic          wdenS;
  logic          rdenS;
  logic          ovfHitS;
  logic          udfHitS;

  // State register; reset forces INIT ahead of any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR <= INIT;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Next-state: INIT holds only while flush is high, RUN leaves on flush.
  always_comb begin
    stateNextS = stateR;
    case (stateR)
      INIT: begin
        if (bus.flush) begin
          stateNextS = INIT;
        end else begin
          stateNextS = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          stateNextS = INIT;
        end else begin
          stateNextS = RUN;
        end
      end
      default: stateNextS = INIT;
    endcase
  end

  // Accept/reject decode; full and empty come from the registered count only.
  always_comb begin
    runS       = (stateR == RUN);
    fullS      = (countR == FULL_COUNT);
    emptyS     = (countR == ZERO_COUNT);
    wdenS      = bus.push & ~fullS  & runS & ~bus.flush;
    rdenS      = bus.pop  & ~emptyS & runS & ~bus.flush;
    ovfHitS    = bus.push &  fullS  & runS & ~bus.flush;
    udfHitS    = bus.pop  &  emptyS & runS & ~bus.flush;
    countNextS = countR;
    if (bus.flush) begin
      countNextS = ZERO_COUNT;
    end else if (runS) begin
      countNextS = countR + {{(CW-1){1'b0}}, wdenS} - {{(CW-1){1'b0}}, rdenS};
    end else begin
      countNextS = countR;
    end
  end

  // Occupancy, read-data-valid and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      countR   <= ZERO_COUNT;
      ovfR     <= 1'b0;
      udfR     <= 1'b0;
      rdValidR <= 1'b0;
    end else begin
      countR   <= countNextS;
      rdValidR <= rdenS;
      if (bus.flush) begin
        ovfR <= 1'b0;
        udfR <= 1'b0;
      end else begin
        ovfR <= ovfR | ovfHitS;
        udfR <= udfR | udfHitS;
      end
    end
  end

  assign bus.wden     = wdenS;
  assign bus.rden     = rdenS;
  assign bus.WrPtrClr = (stateR == INIT);
  assign bus.RdPtrClr = (stateR == INIT);
  assign bus.busy     = (stateR == INIT);
  assign bus.count    = countR;
  assign bus.full     = fullS;
  assign bus.empty    = emptyS;
  assign bus.rd_valid = rdValidR;
  assign bus.ovf      = ovfR;
  assign bus.udf      = udfR;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: occupancy model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fifo_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_ctrl_if #(.CW(4)) bus();
  fifo_ctrl #(.DEPTH(8), .CW(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: occupancy as a plain integer, busy while pointers are being cleared.
  int occ;
  bit mBusy, mOvf, mUdf, mRdv, known;
  initial begin
    occ = 0; mBusy = 1'b1; mOvf = 1'b0; mUdf = 1'b0; mRdv = 1'b0; known = 1'b0;
  end

  always @(posedge clk) begin
    bit live, takePush, takePop;
    if (reset) begin
      known = 1'b1; mBusy = 1'b1; occ = 0; mOvf = 1'b0; mUdf = 1'b0; mRdv = 1'b0;
    end else if (known) begin
      live     = !mBusy && !bus.flush;
      takePush = live && bus.push && (occ < 8);
      takePop  = live && bus.pop && (occ > 0);
      mRdv     = takePop;
      if (bus.flush) begin
        occ = 0; mOvf = 1'b0; mUdf = 1'b0; mBusy = 1'b1;
      end else if (mBusy) begin
        mBusy = 1'b0;
      end else begin
        if (bus.push && occ == 8) mOvf = 1'b1;
        if (bus.pop && occ == 0) mUdf = 1'b1;
        occ = occ + int'(takePush) - int'(takePop);
      end
    end
  end

  always @(negedge clk) begin
    int expW, expR;
    if (known) begin
      expW = int'(!mBusy && !bus.flush && bus.push && occ < 8);
      expR = int'(!mBusy && !bus.flush && bus.pop && occ > 0);
      check("m_wden", bus.wden, expW);
      check("m_rden", bus.rden, expR);
      check("m_wrclr", bus.WrPtrClr, mBusy);
      check("m_rdclr", bus.RdPtrClr, mBusy);
      check("m_busy", bus.busy, mBusy);
      check("m_count", bus.count, occ);
      check("m_full", bus.full, int'(occ == 8));
      check("m_empty", bus.empty, int'(occ == 0));
      check("m_rdvalid", bus.rd_valid, mRdv);
      check("m_ovf", bus.ovf, mOvf);
      check("m_udf", bus.udf, mUdf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input bit q, input bit f);
    bus.push = p; bus.pop = q; bus.flush = f;
  endtask

  initial begin
    int nW, nR;
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    #1;
    check("rst_busy", bus.busy, 1);
    check("rst_wrclr", bus.WrPtrClr, 1);
    check("rst_wden", bus.wden, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #1;
    check("rel_busy", bus.busy, 1);
    check("rel_rdclr", bus.RdPtrClr, 1);
    tick();
    check("run_busy", bus.busy, 0);
    check("run_count", bus.count, 0);
    check("run_empty", bus.empty, 1);

    // Fill to 8, then one push too many.
    nW = 0;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #1; nW += int'(bus.wden); tick();
    end
    check("fill_wden_pulses", nW, 8);
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, 8);
    #1;
    check("ovf_wden", bus.wden, 0);
    tick();
    check("ovf_set", bus.ovf, 1);
    check("ovf_count", bus.count, 8);

    // Full: push + pop together.
    drive(1'b1, 1'b1, 1'b0);
    #1;
    check("fpp_wden", bus.wden, 0);
    check("fpp_rden", bus.rden, 1);
    tick();
    check("fpp_count", bus.count, 7);
    check("fpp_ovf", bus.ovf, 1);
    check("fpp_rdvalid", bus.rd_valid, 1);

    // Flush, pop during INIT is dropped, then push + pop from empty.
    drive(1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    check("init_pop_udf", bus.udf, 0);
    check("init_pop_busy", bus.busy, 0);
    drive(1'b1, 1'b1, 1'b0);
    #1;
    check("epp_wden", bus.wden, 1);
    check("epp_rden", bus.rden, 0);
    tick();
    check("epp_count", bus.count, 1);
    check("epp_udf", bus.udf, 1);

    // Count 3, streaming push + pop for 10 cycles.
    drive(1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    check("s3_count", bus.count, 3);
    nR = 0;
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(); nR += int'(bus.rd_valid);
    end
    check("s3_rdvalid_cycles", nR, 10);
    check("s3_count_after", bus.count, 3);
    check("s3_ovf", bus.ovf, 0);
    check("s3_udf", bus.udf, 0);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("s3_rdvalid_drop", bus.rd_valid, 0);

    // Count 5 with ovf set, then flush together with push.
    drive(1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0);
    repeat (9) tick();
    drive(1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    drive(1'b0, 1'b0, 1'b0);
    check("c5_count", bus.count, 5);
    check("c5_ovf", bus.ovf, 1);
    drive(1'b1, 1'b0, 1'b1);
    #1;
    check("fl_wden", bus.wden, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check("fl_busy", bus.busy, 1);
    check("fl_wrclr", bus.WrPtrClr, 1);
    check("fl_count", bus.count, 0);
    check("fl_ovf", bus.ovf, 0);
    tick();
    check("fl_run", bus.busy, 0);

    // Reset wins over flush/push mid-run.
    drive(1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    check("pri_pre_count", bus.count, 2);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    tick();
    check("pri_count", bus.count, 0);
    check("pri_busy", bus.busy, 1);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick();

    // Mixed directed pattern, checked by the model every cycle.
    for (int i = 0; i < 80; i++) begin
      drive(bit'(i % 3 != 0), bit'((i % 5) < 2 || i > 60), bit'(i == 37));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
